// File: rtl/tree_input_ctrl.sv
// Input-port stage of the tree router: buffers upstream packets in a small FIFO
// and steers the head packet to one of two branches by a destination-address bit.
module tree_input_ctrl #(
    parameter int WIDTH_packet = 14,
    parameter int DEPTH        = 4,
    parameter int DEST_LSB     = 10,
    parameter int DEST_W       = 4,
    parameter int LEVEL        = 0,
    parameter int CNT_W        = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [WIDTH_packet-1:0] in_data_i,
    output logic                    out0_valid_o,
    input  logic                    out0_ready_i,
    output logic [WIDTH_packet-1:0] out0_data_o,
    output logic                    out1_valid_o,
    input  logic                    out1_ready_i,
    output logic [WIDTH_packet-1:0] out1_data_o,
    output logic [CNT_W-1:0]        cnt0_o,
    output logic [CNT_W-1:0]        cnt1_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam int ROUTE_BIT = DEST_LSB + LEVEL;

    logic [WIDTH_packet-1:0] mem_q [DEPTH];
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [CNT_W-1:0]        cnt0_q, cnt0_d;
    logic [CNT_W-1:0]        cnt1_q, cnt1_d;

    logic [WIDTH_packet-1:0] head;
    logic                    route;
    logic                    not_empty;
    logic                    push;
    logic                    pop0;
    logic                    pop1;
    logic                    pop;

    assign head      = mem_q[rd_ptr_q];
    assign route     = head[ROUTE_BIT];
    assign not_empty = (count_q != '0);

    assign in_ready_o   = (count_q != FULL_CNT);
    assign out0_valid_o = not_empty && !route;
    assign out1_valid_o = not_empty && route;
    assign out0_data_o  = head;
    assign out1_data_o  = head;
    assign cnt0_o       = cnt0_q;
    assign cnt1_o       = cnt1_q;

    assign push = in_valid_i && in_ready_o;
    assign pop0 = out0_valid_o && out0_ready_i;
    assign pop1 = out1_valid_o && out1_ready_i;
    assign pop  = pop0 || pop1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (pop0) begin
            cnt0_d = cnt0_q + CNT_W'(1);
        end
        if (pop1) begin
            cnt1_d = cnt1_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Storage is never cleared; a push during reset is suppressed.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_tree_input_ctrl.sv
// Directed bench for tree_input_ctrl: a LEVEL=0 instance for routing, full and
// reset cases, and a LEVEL=2 instance for pointer wrap under varied ready patterns.
module tb_tree_input_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [13:0] in_data_i;
    logic        out0_valid_o, out0_ready_i;
    logic [13:0] out0_data_o;
    logic        out1_valid_o, out1_ready_i;
    logic [13:0] out1_data_o;
    logic [15:0] cnt0_o, cnt1_o;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [13:0] b_in_data;
    logic        b_o0v, b_o0r, b_o1v, b_o1r;
    logic [13:0] b_o0d, b_o1d;
    logic [15:0] b_cnt0, b_cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    tree_input_ctrl #(.LEVEL(0)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out0_valid_o(out0_valid_o), .out0_ready_i(out0_ready_i), .out0_data_o(out0_data_o),
        .out1_valid_o(out1_valid_o), .out1_ready_i(out1_ready_i), .out1_data_o(out1_data_o),
        .cnt0_o(cnt0_o), .cnt1_o(cnt1_o)
    );

    tree_input_ctrl #(.LEVEL(2)) dut_l2 (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .out0_valid_o(b_o0v), .out0_ready_i(b_o0r), .out0_data_o(b_o0d),
        .out1_valid_o(b_o1v), .out1_ready_i(b_o1r), .out1_data_o(b_o1d),
        .cnt0_o(b_cnt0), .cnt1_o(b_cnt1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
    endtask

    localparam logic [13:0] P1 = 14'b10100000100000; // branch 0
    localparam logic [13:0] P2 = 14'b01011111000000; // branch 1
    localparam logic [13:0] P3 = 14'b01101010111110; // branch 0
    localparam logic [13:0] P4 = 14'b11000100111110; // branch 0
    localparam logic [13:0] B1 = 14'b00010000000001;
    localparam logic [13:0] B2 = 14'b00010000000010;
    localparam logic [13:0] B3 = 14'b00010000000011;
    localparam logic [13:0] B4 = 14'b00010000000100;

    initial begin
        logic [15:0] pat0, pat1;
        logic [13:0] exp_pkt;
        int          n_sent, n_recv, cyc;

        rst_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = P1;
        out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        b_in_valid = 1'b0; b_in_data = '0; b_o0r = 1'b0; b_o1r = 1'b0;

        // Reset held two cycles with in_valid high
        tick(); tick();
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_out0_valid", 32'(out0_valid_o), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid_o), 32'd0);
        chk("rst_cnt0", 32'(cnt0_o), 32'd0);
        chk("rst_cnt1", 32'(cnt1_o), 32'd0);
        rst_i = 1'b0; in_valid_i = 1'b0;
        tick();
        chk("rst_nothing_queued", 32'({out0_valid_o, out1_valid_o}), 32'd0);

        // Single routing, branch 0 then branch 1
        out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = P1;
        tick();
        in_valid_i = 1'b0;
        chk("single0_valid", 32'({out0_valid_o, out1_valid_o}), 32'b10);
        chk("single0_data", 32'(out0_data_o), 32'(P1));
        chk("single0_cnt_before", 32'(cnt0_o), 32'd0);
        tick();
        chk("single0_cnt0", 32'(cnt0_o), 32'd1);
        chk("single0_empty", 32'({out0_valid_o, out1_valid_o}), 32'd0);
        in_valid_i = 1'b1; in_data_i = P2;
        tick();
        in_valid_i = 1'b0;
        chk("single1_valid", 32'({out0_valid_o, out1_valid_o}), 32'b01);
        chk("single1_data", 32'(out1_data_o), 32'(P2));
        tick();
        chk("single1_cnt1", 32'(cnt1_o), 32'd1);
        chk("single1_cnt0", 32'(cnt0_o), 32'd1);

        // Back-to-back alternating with both readies high
        do_reset();
        in_valid_i = 1'b1; in_data_i = P3;
        tick();
        chk("b2b_first_valid", 32'({out0_valid_o, out1_valid_o}), 32'b10);
        chk("b2b_first_data", 32'(out0_data_o), 32'(P3));
        in_data_i = P2;
        tick();
        in_valid_i = 1'b0;
        chk("b2b_second_valid", 32'({out0_valid_o, out1_valid_o}), 32'b01);
        chk("b2b_second_data", 32'(out1_data_o), 32'(P2));
        chk("b2b_cnt0_mid", 32'(cnt0_o), 32'd1);
        tick();
        chk("b2b_cnts", 32'({cnt0_o, cnt1_o}), {16'd1, 16'd1});
        chk("b2b_empty", 32'({out0_valid_o, out1_valid_o}), 32'd0);

        // Full and head-of-line blocking
        do_reset();
        out0_ready_i = 1'b0; out1_ready_i = 1'b1;
        in_valid_i = 1'b1; in_data_i = P4;
        tick();
        chk("hol_ready_after1", 32'(in_ready_o), 32'd1);
        in_data_i = B1; tick();
        in_data_i = B2; tick();
        in_data_i = B3; tick();
        chk("hol_full_in_ready", 32'(in_ready_o), 32'd0);
        chk("hol_out1_blocked", 32'({out0_valid_o, out1_valid_o}), 32'b10);
        chk("hol_head_data", 32'(out0_data_o), 32'(P4));
        in_data_i = B4;          // must not be taken while full
        out0_ready_i = 1'b1;
        tick();
        out0_ready_i = 1'b0; in_valid_i = 1'b0;
        chk("hol_ready_back", 32'(in_ready_o), 32'd1);
        chk("hol_cnt0", 32'(cnt0_o), 32'd1);
        chk("hol_b1_valid", 32'({out0_valid_o, out1_valid_o}), 32'b01);
        chk("hol_b1_data", 32'(out1_data_o), 32'(B1));
        tick();
        chk("hol_b2_data", 32'(out1_data_o), 32'(B2));
        tick();
        chk("hol_b3_data", 32'(out1_data_o), 32'(B3));
        tick();
        chk("hol_drained", 32'({out0_valid_o, out1_valid_o}), 32'd0);
        chk("hol_cnt1", 32'(cnt1_o), 32'd3);

        // Wrap with LEVEL=2: even packets dest 0100 (branch 1), odd dest 0000 (branch 0)
        do_reset();
        pat0 = 16'b1011_0010_1101_0110;
        pat1 = 16'b0110_1101_0011_1011;
        n_sent = 0; n_recv = 0; cyc = 0;
        while (n_recv < 10 && cyc < 200) begin
            b_in_valid = (n_sent < 10);
            b_in_data  = {((n_sent % 2) == 0) ? 4'b0100 : 4'b0000, 10'(n_sent + 1)};
            b_o0r = pat0[cyc % 16];
            b_o1r = pat1[cyc % 16];
            #1;
            if ((b_o0v && b_o0r) || (b_o1v && b_o1r)) begin
                exp_pkt = {((n_recv % 2) == 0) ? 4'b0100 : 4'b0000, 10'(n_recv + 1)};
                chk("wrap_branch", 32'({b_o0v, b_o1v}), ((n_recv % 2) == 0) ? 32'b01 : 32'b10);
                chk("wrap_data", 32'(b_o1v ? b_o1d : b_o0d), 32'(exp_pkt));
                n_recv++;
            end
            if (b_in_valid && b_in_ready) n_sent++;
            tick();
            cyc++;
        end
        b_in_valid = 1'b0; b_o0r = 1'b0; b_o1r = 1'b0;
        chk("wrap_all_received", 32'(n_recv), 32'd10);
        chk("wrap_cnt0", 32'(b_cnt0), 32'd5);
        chk("wrap_cnt1", 32'(b_cnt1), 32'd5);
        chk("wrap_empty", 32'({b_o0v, b_o1v}), 32'd0);

        // Reset mid-operation
        do_reset();
        out0_ready_i = 1'b0; out1_ready_i = 1'b0;
        in_valid_i = 1'b1;
        in_data_i = P1; tick();
        in_data_i = P2; tick();
        in_data_i = P4; tick();
        chk("midrst_pre_valid", 32'({out0_valid_o, out1_valid_o}), 32'b10);
        rst_i = 1'b1; in_data_i = B1;
        tick();
        rst_i = 1'b0; in_valid_i = 1'b0;
        chk("midrst_valids", 32'({out0_valid_o, out1_valid_o}), 32'd0);
        chk("midrst_in_ready", 32'(in_ready_o), 32'd1);
        in_valid_i = 1'b1; in_data_i = P3;
        tick();
        in_valid_i = 1'b0;
        chk("midrst_push_valid", 32'({out0_valid_o, out1_valid_o}), 32'b10);
        chk("midrst_push_data", 32'(out0_data_o), 32'(P3));
        out0_ready_i = 1'b1; out1_ready_i = 1'b1;
        tick();
        chk("midrst_no_stale", 32'({out0_valid_o, out1_valid_o}), 32'd0);
        chk("midrst_cnt0", 32'(cnt0_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tree_input_ctrl.md
# tree_input_ctrl

Clocked input-port stage of the tree router. Accepts packets from one upstream link, buffers them in a small FIFO, and steers each packet to one of two downstream output controllers using one destination-address bit selected by the router's tree level. Order is preserved and the two branches are never reordered. Per-branch packet counters are kept for debug.

## Interface
Parameters:
- WIDTH_packet, 14: packet width in bits.
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- DEST_LSB, 10: bit index of the LSB of the destination field.
- DEST_W, 4: destination field width; the field is packet[DEST_LSB+DEST_W-1 : DEST_LSB].
- LEVEL, 0: tree level of this router, 0..DEST_W-1. The route bit is packet[DEST_LSB+LEVEL].
- CNT_W, 16: width of each per-branch packet counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  upstream packet present.
- in_ready  out  1  FIFO can accept.
- in_data  in  WIDTH_packet  upstream packet.
- out0_valid  out  1  head packet routed to branch 0.
- out0_ready  in  1  branch-0 output controller accepts.
- out0_data  out  WIDTH_packet  head packet.
- out1_valid  out  1  head packet routed to branch 1.
- out1_ready  in  1  branch-1 output controller accepts.
- out1_data  out  WIDTH_packet  head packet.
- cnt0  out  CNT_W  packets delivered on branch 0.
- cnt1  out  CNT_W  packets delivered on branch 1.

## Operation
- **Storage.** Circular FIFO with registered state: wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and count (log2 DEPTH + 1 bits).
- **Push.** A push occurs when in_valid && in_ready.
  - in_ready = (count != DEPTH); it depends on registered state only.
  - When full, no push occurs even if a pop happens in the same cycle.
- **Route bit.** route = head[DEST_LSB+LEVEL], where head = mem[rd_ptr].
- **Output drive.**
  - out0_valid = (count != 0) && !route.
  - out1_valid = (count != 0) && route.
  - Exactly one of out0_valid/out1_valid is high when non-empty; both are low when empty.
  - out0_data and out1_data both carry head at all times. Their value is don't-care when the matching valid is low.
- **Pop.** A pop occurs when (out0_valid && out0_ready) || (out1_valid && out1_ready).
  - A pop advances rd_ptr.
  - It increments cnt0 or cnt1 by 1, wrapping modulo 2^CNT_W.
- **Simultaneous push and pop** (non-full, non-empty): count is unchanged and both pointers advance.
- **Head-of-line blocking.** If the head's branch holds ready low, all later packets wait, including those bound for the other branch. This is intended and keeps per-port order.
- **Handshake rule.** Once a valid is raised it stays high with stable data until accepted or reset. The ready inputs may toggle freely.
- **Reset.**
  - Pointers, count, cnt0 and cnt1 go to 0.
  - out0_valid and out1_valid go to 0; in_ready goes to 1.
  - Memory contents are not cleared.
  - Packets in flight at reset are discarded. If in_valid is high during a reset cycle, no push occurs.

## Timing
- **Latency.** A packet pushed at edge N is visible on outX_valid/outX_data after edge N, i.e. in cycle N+1. There is no same-cycle bypass from an empty FIFO.
- **Throughput.** One packet per cycle in and one out with ready held high.
- **Full / empty.**
  - in_ready drops in the cycle after the push that fills the FIFO.
  - in_ready rises in the cycle after the first pop from full.
- **Counters.** cnt0 and cnt1 update at the same edge as the pop.
- **Reset timing.** rst sampled high at an edge → all outputs take their reset values in the following cycle.

## Test plan
- **Reset.** Assert rst for 2 cycles with in_valid=1 → in_ready=1, out0_valid=out1_valid=0, cnt0=cnt1=0, and nothing is queued after release.
- **Single routing (LEVEL=0).** Push 14'b10100000100000 (route bit 0) with out0_ready=1 → out0_valid one cycle later with that data, cnt0=1. Then push 14'b01011111000000 (route bit 1) → appears on out1, cnt1=1.
- **Back-to-back alternating.** Push 14'b01101010111110 (branch 0) then 14'b01011111000000 (branch 1) on consecutive cycles, both readies held 1 → delivered in that order on consecutive cycles, cnt0=1, cnt1=1.
- **Full and head-of-line blocking.** Hold out0_ready=0 and push 14'b11000100111110 (branch 0) followed by three branch-1 packets.
  - After 4 pushes, in_ready=0 and out1_valid=0.
  - Raise out0_ready for one cycle → branch-0 packet delivered, then branch-1 packets drain in order.
  - in_ready returns to 1 one cycle after the first pop.
- **Wrap and LEVEL variant.** With LEVEL=2, push 10 packets alternating dest 4'b0100 (branch 1) and 4'b0000 (branch 0) under random ready patterns → order preserved across pointer wrap, cnt0=5, cnt1=5.
- **Reset mid-operation.** Fill 3 entries, assert rst for 1 cycle → count=0, valids low next cycle. A subsequent push is delivered with latency 1 and no stale data appears.
